// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: shared definitions for the universal shift register.
//   - Operation encodings carried on cmd_op (OP_HOLD .. OP_ASR).
//   - FSM state type for the bit-serial sequencer.
//   - sat_amt(): clamps a requested shift count to the register width.
package univ_shift_pkg;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ASR  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Shifting by more than the width gives the same result as shifting by the
  // width (all original bits gone), so larger counts are clamped.
  function automatic int unsigned sat_amt(input int unsigned amt,
                                          input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

endpackage

// File: rtl/univ_shift_unit.sv
// univ_shift_unit: combinational shift/rotate datapath.
//   Default build: applies one step of op_i when amt_i != 0, else passes d_i.
//   UNIV_SHIFT_BARREL_EN build: applies amt_i steps (0..WIDTH) in one pass.
// Ports:
//   d_i      current register value
//   op_i     operation (non-shift ops pass d_i through)
//   amt_i    number of steps to apply (saturated by the caller)
//   serial_i fill bit for SHL/SHR
//   d_o      value after the steps
//   serial_o last bit shifted/rotated out (0 when no step is applied)
module univ_shift_unit
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] d_i,
  input  logic [2:0]       op_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] d_o,
  output logic             serial_o
);

`ifdef UNIV_SHIFT_BARREL_EN
  localparam int STAGES = WIDTH;
`else
  localparam int STAGES = 1;
`endif

  // Returns {bit_out, next_value} for a single step.
  function automatic logic [WIDTH:0] step_f(input logic [WIDTH-1:0] d,
                                            input logic [2:0]       op,
                                            input logic             sin);
    logic [WIDTH:0] r;
    case (op)
      OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], sin};
      OP_SHR:  r = {d[0], sin, d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      OP_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  // Chain of identical single-step stages; stage gi is enabled when more than
  // gi steps were requested. Chaining keeps the barrel result bit-identical
  // to repeated serial steps with the same fill bit.
  logic [WIDTH-1:0] stage_d [0:STAGES];
  logic             stage_s [0:STAGES];

  assign stage_d[0] = d_i;
  assign stage_s[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH:0] r;
      logic           en;
      assign r  = step_f(stage_d[gi], op_i, serial_i);
      assign en = (amt_i > AMT_W'(gi));
      assign stage_d[gi+1] = en ? r[WIDTH-1:0] : stage_d[gi];
      assign stage_s[gi+1] = en ? r[WIDTH]     : stage_s[gi];
    end
  endgenerate

  assign d_o      = stage_d[STAGES];
  assign serial_o = stage_s[STAGES];

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with command handshake.
// Build option: define UNIV_SHIFT_BARREL_EN for single-cycle barrel shifts
// (no SHIFT state, busy tied 0, cmd_ready tied 1). Default is bit-serial.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready command handshake; ready = ~busy
//   cmd_op         0 HOLD,1 LOAD,2 CLR,3 SHL,4 SHR,5 ROL,6 ROR,7 ASR
//   cmd_amt        shift/rotate count (saturates at WIDTH)
//   data_in        parallel load value
//   serial_in      fill bit for SHL/SHR, sampled every step
//   data_out       register contents
//   serial_out     last bit shifted/rotated out
//   busy           multi-cycle shift in progress
//   done           one-cycle completion pulse
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [AMT_W-1:0] amt_sat;
  logic [2:0]       unit_op;
  logic [AMT_W-1:0] unit_amt;
  logic [WIDTH-1:0] unit_d;
  logic             unit_s;

  assign amt_sat = AMT_W'(sat_amt(32'(cmd_amt), WIDTH));

`ifndef UNIV_SHIFT_BARREL_EN
  state_t           state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;

  // In SHIFT the unit replays the latched op one step at a time; in IDLE it
  // computes the first step of the incoming command so that step lands at E0.
  assign unit_op  = (state_q == ST_SHIFT) ? op_q : cmd_op;
  assign unit_amt = (state_q == ST_SHIFT) ? AMT_W'(1) : amt_sat;
  assign busy      = (state_q == ST_SHIFT);
  assign cmd_ready = ~busy;
`else
  assign unit_op   = cmd_op;
  assign unit_amt  = amt_sat;
  assign busy      = 1'b0;
  assign cmd_ready = 1'b1;
`endif

  univ_shift_unit #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_unit (
    .d_i      (data_q),
    .op_i     (unit_op),
    .amt_i    (unit_amt),
    .serial_i (serial_in),
    .d_o      (unit_d),
    .serial_o (unit_s)
  );

  always_comb begin
    data_d = data_q;
    sout_d = sout_q;
    done_d = 1'b0;
`ifndef UNIV_SHIFT_BARREL_EN
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    if (state_q == ST_SHIFT) begin
      data_d = unit_d;
      sout_d = unit_s;
      rem_d  = rem_q - AMT_W'(1);
      if (rem_q == AMT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else
`endif
    if (cmd_valid) begin
      done_d = 1'b1;
      case (cmd_op)
        OP_HOLD: ;
        OP_LOAD: data_d = data_in;
        OP_CLR:  data_d = '0;
        default: begin
          if (amt_sat != '0) begin
            data_d = unit_d;
            sout_d = unit_s;
`ifndef UNIV_SHIFT_BARREL_EN
            // Remaining steps continue in SHIFT; done waits for the last one.
            if (amt_sat > AMT_W'(1)) begin
              state_d = ST_SHIFT;
              rem_d   = amt_sat - AMT_W'(1);
              op_d    = cmd_op;
              done_d  = 1'b0;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
      done_q <= done_d;
    end
  end

`ifndef UNIV_SHIFT_BARREL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_HOLD;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end
`endif

  assign data_out   = data_q;
  assign serial_out = sout_q;
  assign done       = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (default bit-serial build, WIDTH=8).
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [AMT_W-1:0] cmd_amt = '0;
  logic [WIDTH-1:0] data_in = '0;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .data_in(data_in),
    .serial_in(serial_in), .data_out(data_out), .serial_out(serial_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (the acceptance edge E0).
  task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; data_in = d;
    tick();
    cmd_valid = 1'b0;
    $display("cmd op=%0d amt=%0d din=%h -> dout=%h sout=%b busy=%b done=%b",
             op, amt, d, data_out, serial_out, busy, done);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", data_out); end
    n_cmp++; if (serial_out !== 1'b0) begin n_err++; $display("FAIL rst_sout got %b want 0", serial_out); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_flags got busy=%b done=%b want 0 0", busy, done); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    serial_in = 1'b0;
    issue(3'd1, 4'd0, 8'hA5);
    issue(3'd3, 4'd5, 8'h00);        // step 1 at E0: A5 -> 4A
    tick();                          // step 2 at E1: 4A -> 94
    n_cmp++; if (data_out !== 8'h94) begin n_err++; $display("FAIL midrst_pre got %h want 94", data_out); end
    rst = 1'b1;
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL midrst_data got %h want 00", data_out); end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_flags got busy=%b ready=%b want 0 1", busy, cmd_ready); end
    rst = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b0 || data_out !== 8'h00) begin n_err++; $display("FAIL midrst_after got done=%b data=%h want 0 00", done, data_out); end
    $display("reset mid-shift: dout=%h busy=%b done=%b", data_out, busy, done);
  endtask

  task automatic test_load();
    issue(3'd1, 4'd0, 8'hA5);
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL load_data got %h want a5", data_out); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL load_done got %b want 1", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL load_done_width got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_op = 3'd1; data_in = 8'h3C; cmd_amt = 4'd0;
    tick();
    n_cmp++; if (data_out !== 8'h3C || cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_load got data=%h ready=%b want 3c 1", data_out, cmd_ready); end
    cmd_op = 3'd0; data_in = 8'hFF;  // HOLD accepted at E1
    tick();
    n_cmp++; if (data_out !== 8'h3C || done !== 1'b1) begin n_err++; $display("FAIL b2b_hold got data=%h done=%b want 3c 1", data_out, done); end
    cmd_op = 3'd1; data_in = 8'hA5;
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (data_out !== 8'hA5) begin n_err++; $display("FAIL b2b_reload got %h want a5", data_out); end
    $display("back-to-back LOAD/HOLD/LOAD: dout=%h", data_out);
  endtask

  task automatic test_shl();
    serial_in = 1'b1;
    issue(3'd3, 4'd3, 8'h00);
    n_cmp++; if (data_out !== 8'h4B || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL shl_e0 got data=%h busy=%b done=%b want 4b 1 0", data_out, busy, done); end
    tick();
    n_cmp++; if (data_out !== 8'h97 || busy !== 1'b1 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL shl_e1 got data=%h busy=%b ready=%b want 97 1 0", data_out, busy, cmd_ready); end
    tick();
    n_cmp++; if (data_out !== 8'h2F || busy !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL shl_e2 got data=%h busy=%b done=%b want 2f 0 1", data_out, busy, done); end
    n_cmp++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL shl_sout got %b want 1", serial_out); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL shl_done_width got %b want 0", done); end
  endtask

  task automatic test_ror_busy_ignore();
    issue(3'd6, 4'd4, 8'h00);        // 2F -> 97
    n_cmp++; if (data_out !== 8'h97) begin n_err++; $display("FAIL ror_e0 got %h want 97", data_out); end
    // Competing LOAD held while busy; it must be dropped, not queued.
    cmd_valid = 1'b1; cmd_op = 3'd1; data_in = 8'h00;
    tick();                          // 97 -> CB
    tick();                          // CB -> E5
    n_cmp++; if (data_out !== 8'hE5 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL ror_e2 got data=%h ready=%b want e5 0", data_out, cmd_ready); end
    tick();                          // E5 -> F2
    cmd_valid = 1'b0;
    n_cmp++; if (data_out !== 8'hF2 || serial_out !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL ror_final got data=%h sout=%b done=%b want f2 1 1", data_out, serial_out, done); end
    tick();
    n_cmp++; if (data_out !== 8'hF2 || done !== 1'b0) begin n_err++; $display("FAIL ror_ignored got data=%h done=%b want f2 0", data_out, done); end
    $display("ror amt4 with competing cmd: dout=%h sout=%b", data_out, serial_out);
  endtask

  task automatic test_asr_saturate();
    int edges;
    bit seen;
    serial_in = 1'b0;
    issue(3'd1, 4'd0, 8'h80);
    n_cmp++; if (serial_out !== 1'b1) begin n_err++; $display("FAIL load_keeps_sout got %b want 1", serial_out); end
    issue(3'd7, 4'd9, 8'h00);
    edges = 1; seen = done;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      edges++;
      seen = done;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL asr_timeout got no done want done within 20 edges"); end
    n_cmp++; if (edges !== 8) begin n_err++; $display("FAIL asr_edges got %0d want 8", edges); end
    n_cmp++; if (data_out !== 8'hFF || serial_out !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL asr_final got data=%h sout=%b busy=%b want ff 1 0", data_out, serial_out, busy); end
    $display("asr amt9: edges=%0d dout=%h sout=%b", edges, data_out, serial_out);
  endtask

  task automatic test_clr_zero_amt();
    issue(3'd2, 4'd0, 8'h55);
    n_cmp++; if (data_out !== 8'h00 || serial_out !== 1'b1) begin n_err++; $display("FAIL clr got data=%h sout=%b want 00 1", data_out, serial_out); end
    serial_in = 1'b1;
    issue(3'd3, 4'd0, 8'h00);
    n_cmp++; if (data_out !== 8'h00 || done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL shl0 got data=%h done=%b busy=%b want 00 1 0", data_out, done, busy); end
  endtask

  task automatic test_rol_shr();
    serial_in = 1'b0;
    issue(3'd1, 4'd0, 8'h81);
    issue(3'd5, 4'd1, 8'h00);        // single-step rotate completes at E0
    n_cmp++; if (data_out !== 8'h03 || serial_out !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL rol1 got data=%h sout=%b done=%b busy=%b want 03 1 1 0", data_out, serial_out, done, busy); end
    issue(3'd4, 4'd2, 8'h00);        // 03 -> 01
    tick();                          // 01 -> 00
    n_cmp++; if (data_out !== 8'h00 || serial_out !== 1'b1 || done !== 1'b1) begin n_err++; $display("FAIL shr2 got data=%h sout=%b done=%b want 00 1 1", data_out, serial_out, done); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_load();
    test_back_to_back();
    test_shl();
    test_ror_busy_ignore();
    test_asr_saturate();
    test_clr_zero_amt();
    test_rol_shr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
